// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART types and constants (state encoding, frame shape).
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmitter frame phases; width is fixed so the encoding never drifts.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_if
//  Brief    : Producer-side handshake and serial line of the UART transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
  import uart_pkg::*;

  logic                      en;
  logic [UART_DATA_BITS-1:0] data_tx;
  logic                      rdy;
  logic                      dout;

  // Producer side: issues requests, watches rdy
  modport master (output en, output data_tx, input rdy, input dout);
  // Transmitter side
  modport slave  (input en, input data_tx, output rdy, output dout);

endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick
//  Brief    : Clocks-per-bit counter; one-cycle tick on the last clock of a
//             bit period. Synchronous clear realigns it to a bit boundary.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  output logic      tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  // Tick comes straight off the counter register, not from any input
  assign tick = (r_count == c_last);

  // Count 0..CLKS_PER_BIT-1, wrapping to 0 at every bit boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Brief    : 8N1 UART transmitter. One byte per request, no buffering; the
//             producer must wait for rdy before the next request.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  wire logic clk,
  input  wire logic rst,
  uart_tx_if.slave  bus
);

  localparam logic [2:0] c_last_bit = 3'(UART_DATA_BITS - 1);

  uart_state_t               r_state;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [2:0]                r_bit_idx;
  logic                      r_dout;
  logic                      r_rdy;
  logic                      w_tick;
  logic                      w_clr;

  // Holding the bit timer at zero while idle makes the accepting edge the
  // start of the first bit period.
  assign w_clr = (r_state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  // Frame sequencer; dout and rdy are loaded with the level of the phase
  // being entered so both leave the block as plain registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_dout    <= UART_STOP_BIT;
      r_rdy     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.en) begin
            r_state   <= START;
            r_shift   <= bus.data_tx;
            r_bit_idx <= '0;
            r_dout    <= UART_START_BIT;
            r_rdy     <= 1'b0;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_dout  <= r_shift[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == c_last_bit) begin
              r_state <= STOP;
              r_dout  <= UART_STOP_BIT;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_dout    <= r_shift[1];
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_rdy   <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_dout  <= UART_STOP_BIT;
          r_rdy   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rdy  = r_rdy;
  assign bus.dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Brief    : Self-checking bench for uart_tx (N=4 instance plus a
//             default-parameter instance) against a frame-timing model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;
  import uart_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic rst_d;

  always #5 clk = ~clk;

  uart_tx_if bus ();
  uart_tx_if dbus ();

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  uart_tx dut_dflt (
    .clk (clk),
    .rst (rst_d),
    .bus (dbus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 50)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-timing model (N=4 instance) ----------------
  int         cyc = 0;
  bit         m_busy = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;
  bit         cmp_on = 1'b0;

  // A frame occupies cycles k..k+10N-1; requests only land while idle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (!m_busy) begin
        if (bus.en === 1'b1) begin
          m_busy = 1'b1;
          m_k    = cyc;
          m_byte = bus.data_tx;
        end
      end else if (cyc - m_k >= 10 * N) begin
        m_busy = 1'b0;
      end
    end
  end

  function automatic logic exp_dout();
    int b;
    if (!m_busy) return 1'b1;
    b = (cyc - m_k) / N;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_dout", bus.dout, exp_dout());
      check("cyc_rdy", bus.rdy, !m_busy);
    end
  end

  // ---------------- rdy run-length monitor ----------------
  int low_run = 0, high_run = 0, last_low = 0, last_high = 0;
  int fall_prev = 0, fall_last = 0, n_falls = 0;
  logic prev_rdy = 1'b1;

  always @(negedge clk) begin
    if (bus.rdy === 1'b1) begin
      if (low_run != 0) last_low = low_run;
      low_run = 0;
      high_run++;
    end else begin
      if (high_run != 0) last_high = high_run;
      if (prev_rdy === 1'b1) begin
        fall_prev = fall_last;
        fall_last = cyc;
        n_falls++;
      end
      high_run = 0;
      low_run++;
    end
    prev_rdy = bus.rdy;
  end

  task automatic send(input logic [7:0] b);
    bus.data_tx = b;
    bus.en      = 1'b1;
    @(negedge clk);
    bus.en      = 1'b0;
  endtask

  // ---------------- default-parameter instance ----------------
  bit d_done = 1'b0;

  initial begin
    int lowcnt;
    dbus.en      = 1'b0;
    dbus.data_tx = 8'hFF;
    rst_d        = 1'b1;
    repeat (3) @(negedge clk);
    rst_d = 1'b0;
    @(negedge clk);
    check("dflt_reset_rdy", dbus.rdy, 1);
    check("dflt_reset_dout", dbus.dout, 1);
    dbus.data_tx = 8'h00;
    dbus.en      = 1'b1;
    @(negedge clk);
    dbus.en = 1'b0;
    lowcnt  = 0;
    while (dbus.dout === 1'b0 && lowcnt < 100000) begin
      lowcnt++;
      @(negedge clk);
    end
    check("dflt_low_run", lowcnt, 93744);
    for (int i = 0; i < 16; i++) begin
      check("dflt_stop_dout", dbus.dout, 1);
      check("dflt_stop_rdy", dbus.rdy, 0);
      @(negedge clk);
    end
    d_done = 1'b1;
  end

  // ---------------- directed scenarios (N=4 instance) ----------------
  initial begin
    logic [9:0] bits10;
    logic [7:0] bits8;
    int         f0;
    bus.en      = 1'b0;
    bus.data_tx = 8'h00;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dout", bus.dout, 1);
    check("reset_rdy", bus.rdy, 1);
    rst    = 1'b0;
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame of 0xAA: levels per bit 0,0,1,0,1,0,1,0,1,1
    send(8'hAA);
    @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      bits10[b] = bus.dout;
      repeat (N) @(negedge clk);
    end
    check("aa_frame_bits", bits10, 10'b11_0101_0100);
    repeat (3) @(negedge clk);
    check("aa_rdy_low_cycles", last_low, 40);

    // Continuous enable: two frames, one idle cycle, starts 41 apart
    f0          = n_falls;
    bus.data_tx = 8'hAA;
    bus.en      = 1'b1;
    repeat (45) @(negedge clk);
    bus.en = 1'b0;
    repeat (50) @(negedge clk);
    check("cont_frames", n_falls - f0, 2);
    check("cont_start_gap", fall_last - fall_prev, 41);
    check("cont_rdy_high_gap", last_high, 1);
    check("cont_rdy_low_cycles", last_low, 40);

    // Data stability: byte changes one cycle after acceptance
    bus.data_tx = 8'h55;
    bus.en      = 1'b1;
    @(negedge clk);
    bus.en      = 1'b0;
    bus.data_tx = 8'hFF;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (N) @(negedge clk);
      bits8[i] = bus.dout;
    end
    check("stab_byte", bits8, 8'h55);
    repeat (N + 6) @(negedge clk);

    // Busy ignore: request during DATA changes nothing
    f0 = n_falls;
    send(8'h0F);
    repeat (3 * N) @(negedge clk);
    bus.data_tx = 8'hF0;
    bus.en      = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (40) @(negedge clk);
    check("busy_frames", n_falls - f0, 1);
    check("busy_idle_rdy", bus.rdy, 1);
    check("busy_idle_run", (high_run >= 10) ? 1 : 0, 1);

    // Reset during data bit 3 of 0x00: line returns high without a clock
    f0 = n_falls;
    send(8'h00);
    repeat (17) @(negedge clk);
    check("pre_rst_dout", bus.dout, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dout", bus.dout, 1);
    check("async_rst_rdy", bus.rdy, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_line", bus.dout, 1);
    end
    check("post_rst_no_frame", n_falls - f0, 1);

    // Let the default-parameter frame finish, bounded
    for (int i = 0; i < 100000 && !d_done; i++) @(negedge clk);
    check("dflt_completed", d_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
